drawing_fill_rect: RTL and testbench
====================================

DRAWING_FILL_RECT -- requirements
Module: drawing_fill_rect

Interface
REQ-001 The block SHALL have parameter X_SIZE, default 640, meaning screen width in pixels.
REQ-002 The block SHALL have parameter Y_SIZE, default 480, meaning screen height in pixels.
REQ-003 The block SHALL have parameter BPP, default 8, meaning bits per pixel; legal values are 8, 16 and 32.
REQ-004 The block SHALL have parameter ADDR_W, default 18, meaning the width of the word address.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 req  input  1  processor start request.
REQ-009 ack  output  1  one-cycle acknowledge; parameters are latched.
REQ-010 busy  output  1  high while the operation is in progress.
REQ-011 r0..r7  input  16 each  parameters: r0[BPP-1:0] colour, r1 x0, r2 y0, r3 width, r4 height; r5..r7 ignored.
REQ-012 de_req  output  1  memory write request.
REQ-013 de_ack  input  1  request accepted this cycle.
REQ-014 de_addr  output  ADDR_W  word address.
REQ-015 de_nbyte  output  4  active-low byte enables; bit i=0 means byte lane i is written.
REQ-016 de_rnw  output  1  tied 0; write only.
REQ-017 de_w_data  output  32  colour replicated 32/BPP times.
REQ-018 de_r_data  input  32  unused.

Function
REQ-019 The block SHALL define P=32/BPP pixels per word and S=log2(P); pixel x lies in word x>>S, at byte lanes (x mod P)*BPP/8 upward.
REQ-020 The FSM SHALL have exactly the states IDLE, SETUP, ROW and NEXT_ROW.
REQ-021 In IDLE, req=1 SHALL latch r0..r4, set ack=1 on the next cycle and move to SETUP; req is otherwise ignored in any other state.
REQ-022 ack SHALL be high for exactly one cycle for each accepted request.
REQ-023 SETUP SHALL clip using at least 17-bit arithmetic: x1=min(x0+width, X_SIZE) and y1=min(y0+height, Y_SIZE).
REQ-024 If width=0, height=0, x0>=X_SIZE or y0>=Y_SIZE, SETUP SHALL go to IDLE with no memory request.
REQ-025 Otherwise SETUP SHALL go to ROW with y=y0 and xw=x0>>S, so that de_req first rises 2 cycles after req is sampled.
REQ-026 In ROW, de_req SHALL be 1, with de_addr=y*(X_SIZE>>S)+xw, truncated to ADDR_W.
REQ-027 de_nbyte SHALL disable byte lanes holding pixels below x0 in the first word and at or above x1 in the last word, where the last word is xw=(x1-1)>>S; both masks apply when the first and last word are the same; all other words SHALL use 4'b0000.
REQ-028 de_addr, de_nbyte and de_w_data SHALL stay stable while de_req=1 and de_ack=0.
REQ-029 On de_ack in ROW, xw SHALL increment, or on the last word of a row the FSM SHALL go to NEXT_ROW.
REQ-030 NEXT_ROW SHALL increment y; if y+1=y1 it SHALL go to IDLE, otherwise it SHALL return to ROW with xw=x0>>S; de_req SHALL be 0 in NEXT_ROW.
REQ-031 busy SHALL be 1 in SETUP, ROW and NEXT_ROW, and 0 only in IDLE.
REQ-032 de_w_data SHALL be {P{colour}}.
REQ-033 de_rnw SHALL be 0 at all times.

Reset
REQ-034 With rst=1 at a clock edge, the block SHALL enter IDLE and set ack=0, at any state including mid-row, with no further de_req.
REQ-035 After reset, busy=0 and de_req=0; de_addr, de_nbyte and de_w_data are don't-care until the next SETUP.
REQ-036 rst SHALL take priority over req arriving in the same cycle.

Verification
REQ-037 Full screen, BPP=8: r0=0x5A, r1=0, r2=0, r3=640, r4=480 -> 76800 writes, addresses 0..76799 in order, de_nbyte=0000 and data 0x5A5A5A5A on every write, then busy=0.
REQ-038 Partial single word: r1=1, r2=2, r3=2, r4=1 -> exactly one write at addr 320 with de_nbyte=4'b1001.
REQ-039 Clip: r1=638, r2=479, r3=10, r4=5 -> exactly one write at addr 76799 with de_nbyte=4'b0011.
REQ-040 Degenerate: r3=0 -> one ack pulse, de_req never asserted, busy=0 by the third cycle after req.
REQ-041 Back-pressure: hold de_ack=0 for 5 cycles mid-row -> de_addr, de_nbyte and de_w_data are unchanged throughout, and no write is skipped or duplicated.
REQ-042 Reset mid-fill: assert rst after 10 de_acks -> the next cycle shows de_req=0, busy=0 and ack=0, and a following req runs the full sequence correctly.

Source files
------------

// File: rtl/drawing_fill_rect.sv
// Rectangle fill engine: clips a rectangle to the screen and streams masked
// word writes of a replicated colour, one row at a time, to a memory port.
module drawing_fill_rect #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int BPP    = 8,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    input  logic [15:0]       r5,
    input  logic [15:0]       r6,
    input  logic [15:0]       r7,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-1:0] de_addr,
    output logic [3:0]        de_nbyte,
    output logic              de_rnw,
    output logic [31:0]       de_w_data,
    input  logic [31:0]       de_r_data
);

    localparam int P  = 32 / BPP;
    localparam int S  = $clog2(P);
    localparam int LB = BPP / 8;
    localparam int XW = X_SIZE >> S;

    typedef enum logic [1:0] {IDLE, SETUP, ROW, NEXT_ROW} state_t;

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic [BPP-1:0]  colour_q, colour_d;
    logic [15:0]     x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [15:0]     y_q, y_d, xw_q, xw_d;
    logic [31:0]     row_base_q, row_base_d;

    logic [16:0]     xsum_s, ysum_s, x1_s, y1_s, xlast_s;
    logic [15:0]     xw_first_s, xw_last_s;
    logic [31:0]     r0_ext_s, addr_s, px_s;
    logic            empty_s, last_row_s;
    logic            unused_s;

    // Clip bounds, word range and address derived from the latched parameters
    always_comb begin
        xsum_s     = {1'b0, x0_q} + {1'b0, w_q};
        ysum_s     = {1'b0, y0_q} + {1'b0, h_q};
        x1_s       = (xsum_s > 17'(X_SIZE)) ? 17'(X_SIZE) : xsum_s;
        y1_s       = (ysum_s > 17'(Y_SIZE)) ? 17'(Y_SIZE) : ysum_s;
        xlast_s    = (x1_s - 17'd1) >> S;
        xw_first_s = x0_q >> S;
        xw_last_s  = xlast_s[15:0];
        empty_s    = (w_q == 16'd0) || (h_q == 16'd0) ||
                     ({1'b0, x0_q} >= 17'(X_SIZE)) || ({1'b0, y0_q} >= 17'(Y_SIZE));
        last_row_s = (({1'b0, y_q} + 17'd1) == y1_s);
        addr_s     = row_base_q + 32'(xw_q);
        r0_ext_s   = {16'd0, r0};
    end

    // Byte enables: a lane is written only if its pixel lies in [x0, x1)
    always_comb begin
        de_nbyte = 4'b1111;
        px_s     = 32'd0;
        for (int p = 0; p < P; p++) begin
            px_s = 32'(xw_q) * 32'(P) + 32'(p);
            for (int b = 0; b < LB; b++) begin
                if ((px_s >= 32'(x0_q)) && (px_s < 32'(x1_s))) begin
                    de_nbyte[p*LB+b] = 1'b0;
                end else begin
                    de_nbyte[p*LB+b] = 1'b1;
                end
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        colour_d   = colour_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        y_d        = y_q;
        xw_d       = xw_q;
        row_base_d = row_base_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = SETUP;
                    ack_d    = 1'b1;
                    colour_d = r0_ext_s[BPP-1:0];
                    x0_d     = r1;
                    y0_d     = r2;
                    w_d      = r3;
                    h_d      = r4;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d    = ROW;
                    y_d        = y0_q;
                    xw_d       = xw_first_s;
                    row_base_d = 32'(y0_q) * 32'(XW);
                end
            end
            ROW: begin
                if (de_ack) begin
                    if (xw_q == xw_last_s) begin
                        state_d = NEXT_ROW;
                    end else begin
                        xw_d = xw_q + 16'd1;
                    end
                end else begin
                    state_d = ROW;
                end
            end
            NEXT_ROW: begin
                y_d = y_q + 16'd1;
                if (last_row_s) begin
                    state_d = IDLE;
                end else begin
                    state_d    = ROW;
                    xw_d       = xw_first_s;
                    row_base_d = row_base_q + 32'(XW);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            colour_q   <= '0;
            x0_q       <= 16'd0;
            y0_q       <= 16'd0;
            w_q        <= 16'd0;
            h_q        <= 16'd0;
            y_q        <= 16'd0;
            xw_q       <= 16'd0;
            row_base_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            colour_q   <= colour_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            y_q        <= y_d;
            xw_q       <= xw_d;
            row_base_q <= row_base_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = (state_q != IDLE);
    assign de_req    = (state_q == ROW);
    assign de_addr   = addr_s[ADDR_W-1:0];
    assign de_rnw    = 1'b0;
    assign de_w_data = {P{colour_q}};
    assign unused_s  = ^{r0_ext_s, r5, r6, r7, de_r_data, addr_s, xlast_s};

endmodule

// File: tb/tb_drawing_fill_rect.sv
// Randomized bench for drawing_fill_rect: a pixel-level reference builds the
// expected write list per rectangle and a monitor checks every write.
module tb_drawing_fill_rect;

    localparam int X_SIZE = 640;
    localparam int Y_SIZE = 480;
    localparam int BPP    = 8;
    localparam int ADDR_W = 18;
    localparam int P      = 32 / BPP;
    localparam int LB     = BPP / 8;
    localparam int WPR    = X_SIZE / P;

    logic              clk, rst, req, ack, busy;
    logic [15:0]       r0, r1, r2, r3, r4, r5, r6, r7;
    logic              de_req, de_ack, de_rnw;
    logic [ADDR_W-1:0] de_addr;
    logic [3:0]        de_nbyte;
    logic [31:0]       de_w_data, de_r_data;

    drawing_fill_rect #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .BPP(BPP), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
        .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       addr;
        logic [3:0] nb;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] exp_data;
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    int          ack_pulses = 0;
    int          ack_mode = 0;
    int          stall_at = -1;
    int          stall_left = 0;
    int          last_addr = -1;
    logic [3:0]  last_nb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: enumerate every covered pixel word by word, row by row
    function automatic void build(input int x0, input int y0, input int w, input int h);
        int x1, y1, pix;
        logic [3:0] nb;
        if (w == 0 || h == 0 || x0 >= X_SIZE || y0 >= Y_SIZE) return;
        x1 = (x0 + w > X_SIZE) ? X_SIZE : x0 + w;
        y1 = (y0 + h > Y_SIZE) ? Y_SIZE : y0 + h;
        for (int y = y0; y < y1; y++) begin
            for (int wd = x0 / P; wd <= (x1 - 1) / P; wd++) begin
                nb = 4'b1111;
                for (int l = 0; l < 4; l++) begin
                    pix = wd * P + l / LB;
                    if (pix >= x0 && pix < x1) nb[l] = 1'b0;
                end
                exp_q.push_back('{addr: (y * WPR + wd) % (1 << ADDR_W), nb: nb});
            end
        end
    endfunction

    // Monitor: checks each presented write, drives de_ack, retires accepted writes
    initial begin
        logic a, prev_ack;
        logic [ADDR_W-1:0] s_addr;
        logic [3:0] s_nb;
        logic [31:0] s_data;
        prev_ack = 1'b0;
        de_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) check("rnw", {63'd0, de_rnw}, 64'd0);
            if (ack === 1'b1 && prev_ack === 1'b1) check("ack_width", 64'd2, 64'd1);
            if (ack === 1'b1) ack_pulses++;
            prev_ack = ack;
            if (de_req === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(de_addr), 64'hFFFF_FFFF);
                end else begin
                    check("addr", 64'(de_addr), 64'(exp_q[0].addr));
                    check("nbyte", 64'(de_nbyte), 64'(exp_q[0].nb));
                    check("data", 64'(de_w_data), 64'(exp_data));
                end
            end
            if (stall_at >= 0 && pops == stall_at && de_req === 1'b1) begin
                stall_left = 5;
                stall_at = -1;
                s_addr = de_addr;
                s_nb = de_nbyte;
                s_data = de_w_data;
            end
            if (stall_left > 0) begin
                check("stall_addr", 64'(de_addr), 64'(s_addr));
                check("stall_nbyte", 64'(de_nbyte), 64'(s_nb));
                check("stall_data", 64'(de_w_data), 64'(s_data));
                stall_left--;
                a = 1'b0;
            end else if (ack_mode == 0) begin
                a = 1'b1;
            end else begin
                a = 1'($urandom_range(0, 1));
            end
            if (de_req === 1'b1 && a && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pops++;
                last_addr = int'(de_addr);
                last_nb = de_nbyte;
            end
            de_ack = a;
            de_r_data = $urandom;
        end
    end

    task automatic wait_idle(input int budget);
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        if (busy !== 1'b0) check("timeout", 64'd1, 64'd0);
    endtask

    task automatic run_rect(input logic [7:0] c, input int x0, input int y0, input int w, input int h);
        int n, p0, a0;
        exp_data = {4{c}};
        build(x0, y0, w, h);
        n = exp_q.size();
        p0 = pops;
        a0 = ack_pulses;
        @(negedge clk);
        r0 = {8'($urandom), c};
        r1 = 16'(x0); r2 = 16'(y0); r3 = 16'(w); r4 = 16'(h);
        r5 = 16'($urandom); r6 = 16'($urandom); r7 = 16'($urandom);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        r1 = 16'($urandom); r3 = 16'($urandom);
        check("ack_hi", {63'd0, ack}, 64'd1);
        check("busy_setup", {63'd0, busy}, 64'd1);
        check("req_setup", {63'd0, de_req}, 64'd0);
        @(negedge clk);
        check("ack_lo", {63'd0, ack}, 64'd0);
        check("req_first", {63'd0, de_req}, {63'd0, (n > 0)});
        if (n == 0) check("busy_degen", {63'd0, busy}, 64'd0);
        wait_idle(10 * n + 100);
        check("left_over", 64'(exp_q.size()), 64'd0);
        check("write_count", 64'(pops - p0), 64'(n));
        check("ack_pulses", 64'(ack_pulses - a0), 64'd1);
        exp_q.delete();
    endtask

    initial begin
        int p0, cnt, x0, y0, w, h;
        rst = 1'b1; req = 1'b0;
        r0 = 16'd0; r1 = 16'd0; r2 = 16'd0; r3 = 16'd0;
        r4 = 16'd0; r5 = 16'd0; r6 = 16'd0; r7 = 16'd0;
        de_r_data = 32'd0;
        exp_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_req", {63'd0, de_req}, 64'd0);
        check("rst_ack", {63'd0, ack}, 64'd0);
        rst = 1'b0;

        // reset beats a simultaneous request
        @(negedge clk);
        rst = 1'b1; req = 1'b1; r3 = 16'd4; r4 = 16'd4;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        check("prio_ack", {63'd0, ack}, 64'd0);
        check("prio_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("prio_ack2", {63'd0, ack}, 64'd0);

        // model pins
        build(1, 2, 2, 1);
        check("pin1_n", 64'(exp_q.size()), 64'd1);
        check("pin1_addr", 64'(exp_q[0].addr), 64'd320);
        check("pin1_nb", 64'(exp_q[0].nb), 64'b1001);
        exp_q.delete();
        build(638, 479, 10, 5);
        check("pin2_n", 64'(exp_q.size()), 64'd1);
        check("pin2_addr", 64'(exp_q[0].addr), 64'd76799);
        check("pin2_nb", 64'(exp_q[0].nb), 64'b0011);
        exp_q.delete();

        ack_mode = 1;
        run_rect(8'hC3, 1, 2, 2, 1);
        check("single_addr", 64'(last_addr), 64'd320);
        check("single_nb", 64'(last_nb), 64'b1001);
        run_rect(8'h3C, 638, 479, 10, 5);
        check("clip_addr", 64'(last_addr), 64'd76799);
        check("clip_nb", 64'(last_nb), 64'b0011);
        run_rect(8'h11, 10, 10, 0, 7);
        run_rect(8'h22, 10, 10, 7, 0);
        run_rect(8'h33, 640, 10, 7, 3);
        run_rect(8'h44, 10, 480, 7, 3);

        // back-pressure mid-row
        ack_mode = 0;
        stall_at = pops + 3;
        run_rect(8'hA5, 100, 10, 40, 2);
        check("stall_done", 64'(stall_left), 64'd0);

        // reset mid-fill, then recovery
        exp_data = 32'h7E7E7E7E;
        build(0, 0, 640, 4);
        p0 = pops;
        @(negedge clk);
        r0 = 16'h007E; r1 = 16'd0; r2 = 16'd0; r3 = 16'd640; r4 = 16'd4;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        cnt = 0;
        while (pops - p0 < 10 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("mid_acks", {63'd0, (pops - p0 >= 10)}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("mid_req", {63'd0, de_req}, 64'd0);
        check("mid_busy", {63'd0, busy}, 64'd0);
        check("mid_ack", {63'd0, ack}, 64'd0);
        run_rect(8'h96, 3, 5, 70, 3);

        // randomized rectangles, including 17-bit wrap candidates
        for (int i = 0; i < 30; i++) begin
            ack_mode = $urandom_range(0, 1);
            x0 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 700);
            y0 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 500);
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 48);
            h  = ($urandom_range(0, 9) == 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 4);
            if (y0 < Y_SIZE && h > 4) y0 = Y_SIZE - 2;
            run_rect(8'($urandom), x0, y0, w, h);
        end

        // full screen
        ack_mode = 0;
        build(0, 0, 640, 480);
        check("full_n", 64'(exp_q.size()), 64'd76800);
        check("full_last", 64'(exp_q[exp_q.size()-1].addr), 64'd76799);
        exp_q.delete();
        run_rect(8'h5A, 0, 0, 640, 480);
        check("full_last_addr", 64'(last_addr), 64'd76799);
        check("full_busy", {63'd0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
